l2_write_buffer: RTL

//  Posted write buffer between the L1 arbiter's L2 port and the L2 cache.

---
 rtl/l2_write_buffer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/l2_write_buffer.sv
// Posted write buffer between the L1 arbiter and L2: coalesces writebacks, drains them when idle, lets reads bypass.
// Optional macro WBUF_FORWARD_EN serves read hits straight from the buffer instead of draining first.
module l2_write_buffer #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          arb_address,
  input  logic                       arb_read,
  input  logic                       arb_write,
  input  logic [LINE_W-1:0]          arb_wdata,
  output logic [LINE_W-1:0]          arb_rdata,
  output logic                       arb_mem_resp,
  output logic [ADDR_W-1:0]          mem_address,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic [LINE_W-1:0]          mem_rdata,
  input  logic                       mem_resp,
  output logic [$clog2(DEPTH+1)-1:0] wb_count
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [LINE_W-1:0] line_q [DEPTH];
  logic [LINE_W-1:0] line_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LINE_W-1:0] arb_rdata_q, arb_rdata_d;
  logic              arb_mem_resp_q, arb_mem_resp_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              full;

  assign req_tag = arb_address[ADDR_W-1:OFF_W];
  assign full    = (count_q == CNT_W'(DEPTH));

  // At most one valid entry can hold a given tag because writes coalesce.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    line_d         = line_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    arb_rdata_d    = '0;
    arb_mem_resp_d = 1'b0;
    mem_address_d  = mem_address_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_wdata_d    = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_write) begin
          if (hit) begin
            line_d[hit_idx] = arb_wdata;
            arb_mem_resp_d  = 1'b1;
            state_d         = S_ACK;
          end else if (!full) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = req_tag;
            line_d[tail_q]  = arb_wdata;
            tail_d          = next_ptr(tail_q);
            count_d         = count_q + CNT_W'(1);
            arb_mem_resp_d  = 1'b1;
            state_d         = S_ACK;
          end else begin
            mem_write_d   = 1'b1;
            mem_address_d = {tag_q[head_q], {OFF_W{1'b0}}};
            mem_wdata_d   = line_q[head_q];
            state_d       = S_DRAIN;
          end
        end else if (arb_read) begin
`ifdef WBUF_FORWARD_EN
          if (hit) begin
            arb_rdata_d    = line_q[hit_idx];
            arb_mem_resp_d = 1'b1;
            state_d        = S_ACK;
          end else begin
`else
          // Without a forwarding path, stale L2 data is avoided by draining until the line leaves the buffer.
          if (hit) begin
            mem_write_d   = 1'b1;
            mem_address_d = {tag_q[head_q], {OFF_W{1'b0}}};
            mem_wdata_d   = line_q[head_q];
            state_d       = S_DRAIN;
          end else begin
`endif
            mem_read_d    = 1'b1;
            mem_address_d = arb_address;
            state_d       = S_READ;
          end
        end else if (count_q != '0) begin
          mem_write_d   = 1'b1;
          mem_address_d = {tag_q[head_q], {OFF_W{1'b0}}};
          mem_wdata_d   = line_q[head_q];
          state_d       = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_resp) begin
          valid_d[head_q] = 1'b0;
          head_d          = next_ptr(head_q);
          count_d         = count_q - CNT_W'(1);
          mem_write_d     = 1'b0;
          mem_address_d   = '0;
          mem_wdata_d     = '0;
          state_d         = S_IDLE;
        end
      end
      S_READ: begin
        if (mem_resp) begin
          arb_rdata_d    = mem_rdata;
          arb_mem_resp_d = 1'b1;
          mem_read_d     = 1'b0;
          mem_address_d  = '0;
          state_d        = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      valid_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      arb_rdata_q    <= '0;
      arb_mem_resp_q <= 1'b0;
      mem_address_q  <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_wdata_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      arb_rdata_q    <= arb_rdata_d;
      arb_mem_resp_q <= arb_mem_resp_d;
      mem_address_q  <= mem_address_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_wdata_q    <= mem_wdata_d;
      tag_q          <= tag_d;
      line_q         <= line_d;
    end
  end

  assign arb_rdata    = arb_rdata_q;
  assign arb_mem_resp = arb_mem_resp_q;
  assign mem_address  = mem_address_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_count     = count_q;
endmodule
